// File: rtl/vec_issue_seq.sv
// Vector issue sequencer: splits a decoded instruction into 4-lane beats.
// Define VSEQ_OVERLAP_EN to let the next instruction be accepted on a completing last beat.
module vec_issue_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] reg_dst,
    input  logic [4:0] reg_s,
    input  logic [4:0] reg_t,
    input  logic       reg_write,
    input  logic       mem_read,
    input  logic       mem_write,
    input  logic [2:0] alu_op,
    input  logic [5:0] vlen,
    input  logic       mem_ready,
    input  logic       flush,
    output logic       issue_valid,
    output logic [3:0] lane_en,
    output logic [4:0] elem_idx,
    output logic [2:0] alu_op_q,
    output logic [4:0] dst_q,
    output logic       wb_en,
    output logic       mem_req,
    output logic       busy,
    output logic       done
);

`ifdef VSEQ_OVERLAP_EN
    localparam bit Overlap = 1'b1;
`else
    localparam bit Overlap = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StIssue, StStall, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] beat_q, beat_d;
    logic [2:0] last_q, last_d;
    logic [1:0] rem_q, rem_d;
    logic [2:0] lat_alu_q, lat_alu_d;
    logic [4:0] lat_dst_q, lat_dst_d;
    logic       lat_rw_q, lat_rw_d;
    logic       lat_mem_q, lat_mem_d;

    logic       issue_q, issue_d;
    logic [3:0] lane_q, lane_d;
    logic [4:0] idx_q, idx_d;
    logic       wb_q, wb_d;
    logic       memreq_q, memreq_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rdy_q, rdy_d;

    logic [5:0] vlen_c;
    logic [5:0] vsum;
    logic [3:0] nbeats;
    logic       active;
    logic       beat_done;
    logic       is_last;
    logic       hazard;
    logic       accept;

    assign vlen_c    = (vlen > 6'd32) ? 6'd32 : vlen;
    assign vsum      = vlen_c + 6'd3;
    assign nbeats    = vsum[5:2];
    assign active    = (state_q == StIssue) || (state_q == StStall);
    assign beat_done = active && (!lat_mem_q || mem_ready);
    assign is_last   = (beat_q == last_q);
    // Incoming instruction reads the register the in-flight one is about to write.
    assign hazard    = lat_rw_q && ((reg_s == lat_dst_q) || (reg_t == lat_dst_q));

    assign in_ready  = rdy_q || (Overlap && beat_done && is_last && !hazard);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        last_d    = last_q;
        rem_d     = rem_q;
        lat_alu_d = lat_alu_q;
        lat_dst_d = lat_dst_q;
        lat_rw_d  = lat_rw_q;
        lat_mem_d = lat_mem_q;
        done_d    = 1'b0;

        if (flush) begin
            state_d = StIdle;
            beat_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StIssue, StStall: begin
                    if (!beat_done) begin
                        state_d = StStall;
                    end else if (!is_last) begin
                        state_d = StIssue;
                        beat_d  = beat_q + 3'd1;
                    end else if (!accept) begin
                        state_d = StDone;
                    end else begin
                        // Old instruction retires in the same cycle the new one starts.
                        done_d = 1'b1;
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase

            if (accept) begin
                lat_alu_d = alu_op;
                lat_dst_d = reg_dst;
                lat_rw_d  = reg_write;
                lat_mem_d = mem_read || mem_write;
                beat_d    = '0;
                last_d    = nbeats[2:0] - 3'd1;
                rem_d     = vlen_c[1:0];
                state_d   = (vlen_c == 6'd0) ? StDone : StIssue;
            end
        end

        if (state_d == StDone) begin
            done_d = 1'b1;
        end

        issue_d = (state_d == StIssue) || (state_d == StStall);
        lane_d  = '0;
        idx_d   = '0;
        if (issue_d) begin
            idx_d  = {beat_d, 2'b00};
            lane_d = ((beat_d == last_d) && (rem_d != 2'd0)) ?
                     ((4'd1 << rem_d) - 4'd1) : 4'hF;
        end
        wb_d     = issue_d && lat_rw_d;
        memreq_d = issue_d && lat_mem_d;
        busy_d   = (state_d != StIdle);
        rdy_d    = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            last_q    <= '0;
            rem_q     <= '0;
            lat_alu_q <= '0;
            lat_dst_q <= '0;
            lat_rw_q  <= 1'b0;
            lat_mem_q <= 1'b0;
            issue_q   <= 1'b0;
            lane_q    <= '0;
            idx_q     <= '0;
            wb_q      <= 1'b0;
            memreq_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            rem_q     <= rem_d;
            lat_alu_q <= lat_alu_d;
            lat_dst_q <= lat_dst_d;
            lat_rw_q  <= lat_rw_d;
            lat_mem_q <= lat_mem_d;
            issue_q   <= issue_d;
            lane_q    <= lane_d;
            idx_q     <= idx_d;
            wb_q      <= wb_d;
            memreq_q  <= memreq_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdy_q     <= rdy_d;
        end
    end

    assign issue_valid = issue_q;
    assign lane_en     = lane_q;
    assign elem_idx    = idx_q;
    assign alu_op_q    = lat_alu_q;
    assign dst_q       = lat_dst_q;
    assign wb_en       = wb_q;
    assign mem_req     = memreq_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vec_issue_seq.sv
// Self-checking bench for vec_issue_seq: directed table, corner sequences, random instructions.
module tb_vec_issue_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [4:0] reg_dst, reg_s, reg_t;
    logic       reg_write, mem_read, mem_write;
    logic [2:0] alu_op;
    logic [5:0] vlen;
    logic       mem_ready, flush;
    logic       issue_valid;
    logic [3:0] lane_en;
    logic [4:0] elem_idx;
    logic [2:0] alu_op_q;
    logic [4:0] dst_q;
    logic       wb_en, mem_req, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    vec_issue_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .reg_dst    (reg_dst),
        .reg_s      (reg_s),
        .reg_t      (reg_t),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_op     (alu_op),
        .vlen       (vlen),
        .mem_ready  (mem_ready),
        .flush      (flush),
        .issue_valid(issue_valid),
        .lane_en    (lane_en),
        .elem_idx   (elem_idx),
        .alu_op_q   (alu_op_q),
        .dst_q      (dst_q),
        .wb_en      (wb_en),
        .mem_req    (mem_req),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_issue"}, int'(issue_valid), 0);
        chk({tag, "_lane"}, int'(lane_en), 0);
        chk({tag, "_idx"}, int'(elem_idx), 0);
        chk({tag, "_alu"}, int'(alu_op_q), 0);
        chk({tag, "_dst"}, int'(dst_q), 0);
        chk({tag, "_wb"}, int'(wb_en), 0);
        chk({tag, "_memreq"}, int'(mem_req), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
    endtask

    // Reference model: beats are derived from element counts; one beat per cycle,
    // each memory beat lingering for its stall count before mem_ready completes it.
    task automatic run_instr(input int vl, input bit rw, input bit mr, input bit mw,
                             input logic [2:0] op, input logic [4:0] d, input int s0,
                             input int rmax, output int n_iv, output int done_cyc);
        int ve, nb, cyc, st, n, k;
        logic [3:0] exp_lane;
        bit memop;
        memop    = mr || mw;
        ve       = (vl > 32) ? 32 : vl;
        nb       = (ve + 3) / 4;
        n_iv     = 0;
        done_cyc = -1;
        k        = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        chk("in_ready_before_accept", int'(in_ready), 1);
        in_valid  = 1'b1;
        reg_dst   = d;
        reg_s     = 5'($urandom);
        reg_t     = 5'($urandom);
        reg_write = rw;
        mem_read  = mr;
        mem_write = mw;
        alu_op    = op;
        vlen      = 6'(vl);
        step();
        cyc       = 1;
        in_valid  = 1'b0;
        vlen      = 6'($urandom);
        alu_op    = 3'($urandom);
        reg_dst   = 5'($urandom);
        for (int b = 0; b < nb; b++) begin
            n = ve - 4 * b;
            if (n > 4) n = 4;
            exp_lane = '0;
            for (int l = 0; l < n; l++) exp_lane[l] = 1'b1;
            st = 0;
            if (memop) begin
                st = (b == 0) ? s0 : 0;
                if (rmax > 0) st += $urandom_range(0, rmax);
            end
            for (int s = 0; s <= st; s++) begin
                chk("beat_issue_valid", int'(issue_valid), 1);
                chk("beat_elem_idx", int'(elem_idx), 4 * b);
                chk("beat_lane_en", int'(lane_en), int'(exp_lane));
                chk("beat_wb_en", int'(wb_en), int'(rw));
                chk("beat_mem_req", int'(mem_req), int'(memop));
                chk("beat_alu_op", int'(alu_op_q), int'(op));
                chk("beat_dst", int'(dst_q), int'(d));
                chk("beat_busy", int'(busy), 1);
                chk("beat_done_low", int'(done), 0);
`ifdef VSEQ_OVERLAP_EN
                if (b != nb - 1) chk("beat_in_ready", int'(in_ready), 0);
`else
                chk("beat_in_ready", int'(in_ready), 0);
`endif
                if (issue_valid) n_iv++;
                if (done) done_cyc = cyc;
                mem_ready = memop ? (s == st) : 1'($urandom_range(0, 1));
                step();
                cyc++;
            end
        end
        chk("done_issue_valid", int'(issue_valid), 0);
        chk("done_busy", int'(busy), 1);
        chk("done_in_ready", int'(in_ready), 0);
        if (done) done_cyc = cyc;
        chk("done_cycle", done_cyc, cyc);
        mem_ready = 1'b1;
        step();
        chk("post_done_low", int'(done), 0);
        chk("post_busy", int'(busy), 0);
        chk("post_in_ready", int'(in_ready), 1);
    endtask

    typedef struct {
        int         vl;
        bit         rw;
        bit         mr;
        bit         mw;
        logic [2:0] op;
        logic [4:0] dst;
        int         s0;
        int         exp_iv;
        int         exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int n_iv, dc, k;
        tbl[0] = '{32, 1'b1, 1'b0, 1'b0, 3'd3, 5'd5,  0, 8, 9};
        tbl[1] = '{7,  1'b0, 1'b0, 1'b0, 3'd1, 5'd2,  0, 2, 3};
        tbl[2] = '{0,  1'b1, 1'b0, 1'b0, 3'd2, 5'd3,  0, 0, 1};
        tbl[3] = '{40, 1'b1, 1'b0, 1'b0, 3'd4, 5'd31, 0, 8, 9};
        tbl[4] = '{5,  1'b0, 1'b0, 1'b0, 3'd6, 5'd1,  0, 2, 3};
        tbl[5] = '{1,  1'b1, 1'b0, 1'b0, 3'd7, 5'd0,  0, 1, 2};
        tbl[6] = '{8,  1'b0, 1'b1, 1'b0, 3'd0, 5'd4,  3, 5, 6};
        tbl[7] = '{63, 1'b0, 1'b0, 1'b1, 3'd2, 5'd8,  0, 8, 9};

        rst_n = 1'b0; in_valid = 1'b0; reg_dst = '0; reg_s = '0; reg_t = '0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_op = '0; vlen = '0;
        mem_ready = 1'b1; flush = 1'b0;

        step();
        step();
        chk_zero("reset");
        rst_n = 1'b1;
        chk("release_in_ready_low", int'(in_ready), 0);
        step();
        chk("release_in_ready_high", int'(in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].vl, tbl[i].rw, tbl[i].mr, tbl[i].mw, tbl[i].op, tbl[i].dst,
                      tbl[i].s0, 0, n_iv, dc);
            chk($sformatf("tbl%0d_issue_cycles", i), n_iv, tbl[i].exp_iv);
            chk($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].exp_done);
        end

        // Flush on beat 3 of 8.
        in_valid = 1'b1; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        vlen = 6'd32; alu_op = 3'd5; reg_dst = 5'd9;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("flush_beat3_idx", int'(elem_idx), 12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_issue_valid", int'(issue_valid), 0);
        chk("flush_no_done", int'(done), 0);
        chk("flush_in_ready", int'(in_ready), 1);
        chk("flush_busy", int'(busy), 0);
        step();
        chk("flush_no_late_done", int'(done), 0);

        // Flush beats in_valid in IDLE.
        in_valid = 1'b1; flush = 1'b1; vlen = 6'd4;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_not_accepted", int'(busy), 0);
        chk("flush_idle_no_issue", int'(issue_valid), 0);

        // Asynchronous reset while stalled.
        in_valid = 1'b1; mem_write = 1'b1; reg_write = 1'b1; vlen = 6'd8;
        alu_op = 3'd5; reg_dst = 5'd13; mem_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        chk("stall_issue_valid", int'(issue_valid), 1);
        chk("stall_idx", int'(elem_idx), 0);
        chk("stall_mem_req", int'(mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        step();
        chk_zero("held_reset");
        rst_n = 1'b1; mem_write = 1'b0; mem_ready = 1'b1;
        step();
        chk("rereset_in_ready", int'(in_ready), 1);
        run_instr(8, 1'b0, 1'b1, 1'b0, 3'd1, 5'd6, 0, 0, n_iv, dc);
        chk("after_reset_beats", n_iv, 2);
        chk("after_reset_done", dc, 3);

`ifdef VSEQ_OVERLAP_EN
        // Independent op accepted on the completing last beat.
        in_valid = 1'b1; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        vlen = 6'd8; reg_dst = 5'd5; alu_op = 3'd1;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1; reg_write = 1'b0; reg_dst = 5'd9; reg_s = 5'd1; reg_t = 5'd2;
        vlen = 6'd4;
        #1;
        chk("ovl_in_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("ovl_no_gap", int'(issue_valid), 1);
        chk("ovl_idx", int'(elem_idx), 0);
        chk("ovl_done_pulse", int'(done), 1);
        chk("ovl_dst", int'(dst_q), 9);
        step();
        chk("ovl_second_done", int'(done), 1);
        step();
        // RAW-dependent op must wait for IDLE.
        in_valid = 1'b1; reg_write = 1'b1; reg_dst = 5'd7; vlen = 6'd4;
        step();
        reg_s = 5'd7; reg_t = 5'd0; reg_dst = 5'd3;
        #1;
        chk("raw_in_ready", int'(in_ready), 0);
        step();
        chk("raw_done_state", int'(issue_valid), 0);
        step();
        chk("raw_idle_ready", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("raw_issue", int'(issue_valid), 1);
        k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        chk("raw_drain", int'(busy), 0);
`endif

        // Random instructions against the model.
        for (int i = 0; i < 25; i++) begin
            bit mr, mw;
            mr = 1'($urandom_range(0, 1));
            mw = mr ? 1'b0 : 1'($urandom_range(0, 1));
            run_instr(int'($urandom_range(0, 45)), 1'($urandom_range(0, 1)), mr, mw,
                      3'($urandom), 5'($urandom), 0, 2, n_iv, dc);
        end

        k = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_issue_seq.md
VEC_ISSUE_SEQ -- requirements
Module: vec_issue_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: decoded instruction present.
REQ-004 SHALL have port in_ready, output, 1 bit: sequencer accepts an instruction this cycle.
REQ-005 SHALL have ports reg_dst, reg_s and reg_t, input, 5 bits each: decoded register fields.
REQ-006 SHALL have ports reg_write, mem_read and mem_write, input, 1 bit each: decoded control.
REQ-007 SHALL have port alu_op, input, 3 bits: decoded ALU operation.
REQ-008 SHALL have port vlen, input, 6 bits: vector length in elements.
REQ-009 SHALL have port mem_ready, input, 1 bit: memory accepts a beat.
REQ-010 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-011 SHALL have port issue_valid, output, 1 bit: a beat is presented to the datapath.
REQ-012 SHALL have port lane_en, output, 4 bits: active lanes of the current beat.
REQ-013 SHALL have port elem_idx, output, 5 bits: first element index of the current beat.
REQ-014 SHALL have ports alu_op_q (output, 3 bits), dst_q (output, 5 bits), wb_en (output, 1 bit) and mem_req (output, 1 bit): latched control driven with each beat.
REQ-015 SHALL have ports busy (output, 1 bit) and done (output, 1 bit, one-cycle pulse).

Function
REQ-016 SHALL implement the states IDLE, ISSUE, STALL and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in_valid=1 SHALL latch all fields and go to ISSUE, or to DONE when vlen=0.
REQ-018 vlen greater than 32 SHALL be clamped to 32; beat count SHALL be ceil(vlen/4), range 1..8.
REQ-019 The first beat SHALL assert issue_valid in the cycle after acceptance (latency 1).
REQ-020 In ISSUE, one beat SHALL issue per cycle; elem_idx SHALL be beat*4.
REQ-021 lane_en SHALL be 4'hF, except on the last beat when vlen mod 4 != 0, where it SHALL be (1<<(vlen mod 4))-1.
REQ-022 For memory ops (mem_read or mem_write): mem_req = issue_valid.
REQ-023 For memory ops, mem_ready=0 during a beat SHALL go to STALL and hold the beat, with outputs stable; mem_ready=1 SHALL complete the beat.
REQ-024 For non-memory ops, mem_ready SHALL be ignored.
REQ-025 wb_en SHALL equal issue_valid AND latched reg_write.
REQ-026 After the last beat completes, the block SHALL enter DONE; done=1 for one cycle, then IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 flush=1 SHALL return the block to IDLE next cycle with issue_valid=0 and no done pulse; flush has priority over all other events, including in_valid in IDLE.
REQ-029 in_ready SHALL be 0 in ISSUE, STALL and DONE, except as relaxed by REQ-034.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and zero all outputs and internal counters, including mid-beat and during STALL.
REQ-031 in_ready SHALL be 0 while rst_n=0 and 1 from the first clock edge after release.

Configuration
REQ-032 Macro VSEQ_OVERLAP_EN SHALL control back-to-back issue.
REQ-033 Without VSEQ_OVERLAP_EN, consecutive instructions SHALL be separated by the DONE cycle plus the IDLE accept cycle.
REQ-034 With VSEQ_OVERLAP_EN, in_ready SHALL also be 1 during a completing last beat, unless a RAW hazard exists: latched reg_write=1 and (reg_s or reg_t equals the latched reg_dst). On accept, the next first beat SHALL issue in the following cycle, with done pulsing in that same cycle.

Verification
REQ-035 ALU op, vlen=32, reg_write=1 -> issue_valid for 8 consecutive cycles starting at cycle 1; elem_idx 0,4,...,28; lane_en=F on every beat; wb_en=1; done pulses at cycle 9.
REQ-036 vlen=7 -> 2 beats with lane_en F then 7; vlen=0 -> no issue_valid and done at cycle 1; vlen=40 -> behaves as vlen=32.
REQ-037 mem_read, vlen=8, mem_ready=0 for 3 cycles on beat 0 -> beat 0 held for 4 cycles with elem_idx=0, then beat 1; done at cycle 6.
REQ-038 flush asserted on beat 3 of 8 -> issue_valid=0 next cycle, no done pulse, in_ready=1.
REQ-039 rst_n low during STALL -> all outputs 0 asynchronously; after release, a new instruction is accepted normally.
REQ-040 VSEQ_OVERLAP_EN: independent back-to-back ops -> no gap between issue streams; a RAW-dependent op waits until IDLE.
